range_down_counter: RTL and testbench
=====================================

// Module: range_down_counter
// PURPOSE
//  One-shot down-counter: on a start pulse, counts from a high bound down to a low bound (default 67 -> 5).
//  Counts exactly once per start, pulses done, then parks in IDLE until restarted.
//  Counterpart to the team's one-shot 5 -> 67 up-counter.
//  Used as a bounded countdown/timeout source; runtime-loadable bounds and hold/abort controls.
// PARAMETERS
//  WIDTH   8   counter/bound width, unsigned
//  DEF_HI  67  high bound after reset (start value)
//  DEF_LO  5   low bound after reset (terminal value)
// PORTS
//  CLK      in   1      single clock; all logic on posedge CLK
//  RESET    in   1      synchronous, active-high reset
//  start    in   1      request a countdown; sampled in IDLE only
//  hold     in   1      freeze count while RUN
//  abort    in   1      cancel any operation, return to IDLE
//  load     in   1      capture load_hi/load_lo; sampled in IDLE only
//  load_hi  in   WIDTH  new high bound
//  load_lo  in   WIDTH  new low bound
//  count    out  WIDTH  current count value
//  busy     out  1      high while RUN
//  done     out  1      one-cycle pulse, countdown reached low bound
//  cfg_err  out  1      sticky: last load rejected (load_hi < load_lo)
// BEHAVIOUR
//  Reset (RESET=1 at posedge CLK):
//   - state=IDLE, count=DEF_HI, hi_reg=DEF_HI, lo_reg=DEF_LO
//   - busy=0, done=0, cfg_err=0; overrides all other inputs
//  FSM states: IDLE, RUN, DONE. All outputs registered.
//  Priority per cycle: RESET > abort > load > start > hold.
//  IDLE:
//   - load, load_hi >= load_lo: hi_reg<=load_hi, lo_reg<=load_lo, count<=load_hi, cfg_err<=0
//   - load, load_hi <  load_lo: bounds and count unchanged, cfg_err<=1
//   - start && !load: state<=RUN, count<=hi_reg, busy<=1
//   - start and load in the same cycle: start ignored
//  RUN:
//   - count==lo_reg (hold ignored): state<=DONE, busy<=0, done<=1, count holds lo_reg
//   - else hold=1: count unchanged
//   - else: count<=count-1
//   - start, load ignored
//  DONE: single cycle; state<=IDLE, done<=0, count stays lo_reg until next start/load/abort
//  abort (any state): state<=IDLE, count<=hi_reg, busy<=0, done<=0; no done pulse
//  Latency, start sampled at edge k, no hold:
//   - count=hi_reg, busy=1 at k+1
//   - count=lo_reg at k+1+(hi-lo)
//   - done=1, busy=0 at k+2+(hi-lo)
//   - defaults: 63 cycles of busy, done at k+64
//  Boundaries:
//   - hi==lo: busy one cycle, done next
//   - count never wraps and never goes below lo_reg; unsigned WIDTH arithmetic
//   - bounds are stable during RUN (load ignored)
//   - RESET mid-RUN: immediate reset values, no done pulse
// STRUCTURE
//  Shared package counter_pkg:
//   - state typedef {IDLE, RUN, DONE}
//   - DEF_HI/DEF_LO defaults shared with the up-counter
//  Sub-module range_cfg_reg: holds hi_reg/lo_reg, validates loads, drives cfg_err
//  Top: FSM plus count datapath
// TESTING
//  1. Reset, start pulse at edge k -> count 67,66..5 on k+1..k+63, done=1 only at k+64, busy 63 cycles
//  2. hold high 4 cycles at count=40 -> count stays 40 four cycles; done delayed by exactly 4
//  3. load hi=10 lo=10, then start -> busy 1 cycle at count=10, done next cycle
//  4. load hi=3 lo=9 -> cfg_err=1, bounds keep 67/5; later load 20/2 -> cfg_err=0, count=20
//  5. abort at count=30 -> next cycle IDLE, count=hi_reg, busy=0, no done; start mid-RUN ignored
//  6. RESET at count=50 -> count=67, busy=0, done=0; start+load same cycle in IDLE -> load only, no RUN

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and defaults for the one-shot range counters.
// Used by both the 5->67 up-counter and the 67->5 down-counter.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned CNT_DEF_HI = 67;
  localparam int unsigned CNT_DEF_LO = 5;

endpackage

// File: rtl/range_cfg_reg.sv
// Bound registers for the range counter: hi/lo with load validation.
// Ports: CLK, RESET, load (pre-gated), load_hi/lo in; hi_reg, lo_reg, cfg_err, load_ok out.
module range_cfg_reg
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEF_HI = CNT_DEF_HI,
  parameter int unsigned DEF_LO = CNT_DEF_LO
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_hi,
  input  logic [WIDTH-1:0] load_lo,
  output logic [WIDTH-1:0] hi_reg,
  output logic [WIDTH-1:0] lo_reg,
  output logic             cfg_err,
  output logic             load_ok
);

  assign load_ok = (load_hi >= load_lo);

  // A rejected load leaves the old bounds in place.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hi_reg  <= WIDTH'(DEF_HI);
      lo_reg  <= WIDTH'(DEF_LO);
      cfg_err <= 1'b0;
    end else if (load) begin
      if (load_ok) begin
        hi_reg  <= load_hi;
        lo_reg  <= load_lo;
        cfg_err <= 1'b0;
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/range_down_counter.sv
// One-shot down-counter hi->lo with hold/abort and loadable bounds.
// Ports: CLK, RESET, start, hold, abort, load, load_hi/lo in; count, busy, done, cfg_err out.
module range_down_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEF_HI = CNT_DEF_HI,
  parameter int unsigned DEF_LO = CNT_DEF_LO
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             hold,
  input  logic             abort,
  input  logic             load,
  input  logic [WIDTH-1:0] load_hi,
  input  logic [WIDTH-1:0] load_lo,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             load_ok;
  logic             cfg_load;

  // Loads only land in IDLE and lose to abort.
  assign cfg_load = load && (state == IDLE) && !abort;

  range_cfg_reg #(
    .WIDTH  (WIDTH),
    .DEF_HI (DEF_HI),
    .DEF_LO (DEF_LO)
  ) u_cfg (
    .CLK     (CLK),
    .RESET   (RESET),
    .load    (cfg_load),
    .load_hi (load_hi),
    .load_lo (load_lo),
    .hi_reg  (hi_reg),
    .lo_reg  (lo_reg),
    .cfg_err (cfg_err),
    .load_ok (load_ok)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      count <= WIDTH'(DEF_HI);
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      count <= hi_reg;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (load) begin
            if (load_ok) count <= load_hi;
          end else if (start) begin
            state <= RUN;
            count <= hi_reg;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          // <= rather than == so the count can never slip under lo.
          if (count <= lo_reg) begin
            state <= DONE;
            count <= lo_reg;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (!hold) begin
            count <= count - ONE;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_range_down_counter.sv
// Directed bench for range_down_counter.
// Inputs change #1 after posedge; outputs are checked there too.
module tb_range_down_counter;

  logic       CLK;
  logic       RESET;
  logic       start;
  logic       hold;
  logic       abort;
  logic       load;
  logic [7:0] load_hi;
  logic [7:0] load_lo;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       cfg_err;

  int vectors = 0;
  int errors  = 0;

  range_down_counter dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .start   (start),
    .hold    (hold),
    .abort   (abort),
    .load    (load),
    .load_hi (load_hi),
    .load_lo (load_lo),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .cfg_err (cfg_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input int c, input int b, input int d);
    chk({tag, ".count"}, 32'(count), c);
    chk({tag, ".busy"},  32'(busy),  b);
    chk({tag, ".done"},  32'(done),  d);
  endtask

  initial begin
    int n;
    RESET = 1'b1; start = 0; hold = 0; abort = 0;
    load = 0; load_hi = 0; load_lo = 0;
    step();
    step();
    chk_all("reset", 67, 0, 0);
    chk("reset.cfg_err", 32'(cfg_err), 0);
    RESET = 1'b0;

    // 1: full default countdown
    start = 1; step(); start = 0;
    chk_all("t1.k1", 67, 1, 0);
    for (int i = 1; i <= 62; i++) begin
      step();
      chk_all($sformatf("t1.k%0d", i + 1), 67 - i, 1, 0);
    end
    step();
    chk_all("t1.done", 5, 0, 1);
    step();
    chk_all("t1.after", 5, 0, 0);

    // 2: hold 4 cycles at 40
    start = 1; step(); start = 0;
    n = 1;
    for (int i = 0; i < 27; i++) begin
      step(); n++;
    end
    chk_all("t2.at40", 40, 1, 0);
    hold = 1;
    for (int i = 0; i < 4; i++) begin
      step(); n++;
      chk_all($sformatf("t2.hold%0d", i), 40, 1, 0);
    end
    hold = 0;
    step(); n++;
    chk_all("t2.resume", 39, 1, 0);
    while (!done && n < 200) begin
      step(); n++;
    end
    chk("t2.done_latency", 32'(n), 68);
    chk_all("t2.done", 5, 0, 1);
    step();

    // 3: hi == lo
    load = 1; load_hi = 10; load_lo = 10;
    step(); load = 0;
    chk("t3.load.count", 32'(count), 10);
    chk("t3.load.cfg_err", 32'(cfg_err), 0);
    start = 1; step(); start = 0;
    chk_all("t3.run", 10, 1, 0);
    step();
    chk_all("t3.done", 10, 0, 1);
    step();
    chk_all("t3.idle", 10, 0, 0);

    // 4: rejected load, then good load
    RESET = 1; step(); RESET = 0;
    load = 1; load_hi = 3; load_lo = 9;
    step(); load = 0;
    chk("t4.bad.cfg_err", 32'(cfg_err), 1);
    chk("t4.bad.count", 32'(count), 67);
    start = 1; step(); start = 0;
    chk_all("t4.bounds_kept", 67, 1, 0);
    abort = 1; step(); abort = 0;
    chk_all("t4.abort", 67, 0, 0);
    chk("t4.cfg_err_sticky", 32'(cfg_err), 1);
    load = 1; load_hi = 20; load_lo = 2;
    step(); load = 0;
    chk("t4.good.cfg_err", 32'(cfg_err), 0);
    chk("t4.good.count", 32'(count), 20);

    // 5: start/load ignored in RUN, abort at 30
    load = 1; load_hi = 40; load_lo = 5;
    step(); load = 0;
    start = 1; step(); start = 0;
    chk_all("t5.start", 40, 1, 0);
    for (int i = 0; i < 8; i++) step();
    chk_all("t5.at32", 32, 1, 0);
    start = 1; load = 1; load_hi = 99; load_lo = 1;
    step(); start = 0; load = 0;
    chk_all("t5.ignored", 31, 1, 0);
    step();
    chk_all("t5.at30", 30, 1, 0);
    abort = 1; step(); abort = 0;
    chk_all("t5.abort", 40, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("t5.idle%0d", i), 40, 0, 0);
    end

    // 6: reset mid-run, start+load collision
    load = 1; load_hi = 67; load_lo = 5;
    step(); load = 0;
    start = 1; step(); start = 0;
    for (int i = 0; i < 17; i++) step();
    chk_all("t6.at50", 50, 1, 0);
    RESET = 1; step(); RESET = 0;
    chk_all("t6.reset", 67, 0, 0);
    step();
    chk_all("t6.post_reset", 67, 0, 0);
    start = 1; load = 1; load_hi = 12; load_lo = 4;
    step(); start = 0; load = 0;
    chk_all("t6.collide", 12, 0, 0);
    step();
    chk_all("t6.no_run", 12, 0, 0);
    start = 1; step(); start = 0;
    chk_all("t6.new_bounds", 12, 1, 0);
    for (int i = 0; i < 8; i++) step();
    chk_all("t6.lo", 4, 1, 0);
    step();
    chk_all("t6.done", 4, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
